// File: rtl/i2c_pkg.sv
// Shared I2C master definitions: address-phase FSM states and protocol constants.
package i2c_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, ACK, FIN} state_t;

  localparam logic [4:0] I2C_HDR_CODE = 5'b11110;
  localparam logic       I2C_RW_WRITE = 1'b0;
  localparam logic       I2C_RW_READ  = 1'b1;
endpackage

// File: rtl/i2c_byte_shifter.sv
// 8-bit MSB-first SDA serialiser; the step after the 8th bit releases the line for ACK.
module i2c_byte_shifter (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] din,
  input  logic       step,
  output logic       sda,
  output logic       sda_oe,
  output logic       byte_sent
);
  logic [7:0] shreg;
  logic [3:0] bitcnt;

  assign byte_sent = (bitcnt == 4'd8);

  // Load leaves the line as-is; the drive only changes on a step.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg  <= '0;
      bitcnt <= '0;
      sda    <= 1'b1;
      sda_oe <= 1'b0;
    end else if (load) begin
      shreg  <= din;
      bitcnt <= '0;
    end else if (step) begin
      if (byte_sent) begin
        sda    <= 1'b1;
        sda_oe <= 1'b0;
      end else begin
        sda    <= shreg[7];
        sda_oe <= 1'b1;
        shreg  <= {shreg[6:0], 1'b0};
        bitcnt <= bitcnt + 4'd1;
      end
    end
  end
endmodule

// File: rtl/i2c_addr_tx.sv
// I2C address-phase transmitter: 7/10-bit address bytes, slave ACK sampling, done/nack/busy.
module i2c_addr_tx
  import i2c_pkg::*;
#(
  parameter int         ADDR_W   = 10,
  parameter logic [4:0] HDR_CODE = I2C_HDR_CODE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic [ADDR_W-1:0] addrIn,
  input  logic              rw,
  input  logic              ten_bit,
  input  logic              hdr_only,
  input  logic              abit,
  input  logic              ack_strobe,
  input  logic              iSDA,
  output logic              oSDA,
  output logic              sda_oe,
  output logic              busy,
  output logic              done,
  output logic              nack
);
  state_t     state, state_n;
  logic [9:0] a_ext;
  logic       ten_eff;
  logic [7:0] byte0, byte1_q, ld_byte;
  logic       two_q, bytecnt_q, nack_q;
  logic       ld, step, nack_set, next_ld, byte_sent;

  always_comb begin
    a_ext = '0;
    a_ext[ADDR_W-1:0] = addrIn;
  end

  assign ten_eff = (ADDR_W == 10) && ten_bit;

  // 10-bit header carries R/W only in the header-only form (after Sr).
  always_comb begin
    if (!ten_eff)     byte0 = {a_ext[6:0], rw};
    else if (hdr_only) byte0 = {HDR_CODE, a_ext[9:8], rw};
    else               byte0 = {HDR_CODE, a_ext[9:8], I2C_RW_WRITE};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n  = state;
    ld       = 1'b0;
    ld_byte  = byte1_q;
    step     = 1'b0;
    nack_set = 1'b0;
    next_ld  = 1'b0;
    if (go) begin
      state_n = SHIFT;
      ld      = 1'b1;
      ld_byte = byte0;
    end else begin
      case (state)
        SHIFT: if (abit) begin
          step = 1'b1;
          if (byte_sent) state_n = ACK;
        end
        ACK: if (ack_strobe) begin
          if (iSDA) begin
            nack_set = 1'b1;
            state_n  = FIN;
          end else if (two_q && !bytecnt_q) begin
            ld      = 1'b1;
            next_ld = 1'b1;
            state_n = SHIFT;
          end else begin
            state_n = FIN;
          end
        end
        FIN:     state_n = IDLE;
        default: state_n = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      nack_q    <= 1'b0;
      byte1_q   <= '0;
      two_q     <= 1'b0;
      bytecnt_q <= 1'b0;
    end else if (go) begin
      nack_q    <= 1'b0;
      byte1_q   <= a_ext[7:0];
      two_q     <= ten_eff && !hdr_only;
      bytecnt_q <= 1'b0;
    end else begin
      if (nack_set) nack_q    <= 1'b1;
      if (next_ld)  bytecnt_q <= 1'b1;
    end
  end

  i2c_byte_shifter u_shift (
    .clk       (clk),
    .rst       (rst),
    .load      (ld),
    .din       (ld_byte),
    .step      (step),
    .sda       (oSDA),
    .sda_oe    (sda_oe),
    .byte_sent (byte_sent)
  );

  assign busy = (state == SHIFT) || (state == ACK);
  assign done = (state == FIN);
  assign nack = nack_q;
endmodule
